// File: rtl/musteri_arbiter.sv
// Two-customer priority arbiter with bounded service window and status lamps.
// Optional starvation aging is enabled by defining ARB_AGING_EN.
module musteri_arbiter #(
   parameter int unsigned SERVICE_CYCLES = 4
`ifdef ARB_AGING_EN
   ,
   parameter int unsigned AGE_LIMIT = 3
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req1,
   input  logic       req2,
   input  logic [1:0] musteri1,
   input  logic [1:0] musteri2,
   input  logic       done,
   output logic       grant1,
   output logic       grant2,
   output logic       yesil,
   output logic       kirmizi,
   output logic       sari
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      GAP
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic       grant1_q, grant1_d;
   logic       grant2_q, grant2_d;
   logic       sari_q, sari_d;
   logic       win2;
   logic       req_own;

`ifdef ARB_AGING_EN
   logic [1:0] loss1_q, loss1_d;
   logic [1:0] loss2_q, loss2_d;
   logic       aged1, aged2;

   assign aged1 = (loss1_q == 2'(AGE_LIMIT));
   assign aged2 = (loss2_q == 2'(AGE_LIMIT));
`endif

   // owner/last encoding: 0 = customer 1, 1 = customer 2
   always_comb begin
      win2 = 1'b0;
      if (req2 && !req1) begin
         win2 = 1'b1;
      end else if (req1 && req2) begin
`ifdef ARB_AGING_EN
         if (aged1 != aged2)
            win2 = aged2;
         else if (aged1)
            win2 = !last_q;
         else
`endif
         if (musteri1 != musteri2)
            win2 = (musteri2 > musteri1);
         else
            win2 = !last_q;
      end
   end

   assign req_own = owner_q ? req2 : req1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
`ifdef ARB_AGING_EN
      loss1_d = loss1_q;
      loss2_d = loss2_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req1 || req2) begin
               state_d = SERVE;
               owner_d = win2;
               last_d  = win2;
               cnt_d   = 8'(SERVICE_CYCLES - 1);
`ifdef ARB_AGING_EN
               if (win2) begin
                  loss2_d = 2'd0;
                  if (req1 && !aged1)
                     loss1_d = loss1_q + 2'd1;
               end else begin
                  loss1_d = 2'd0;
                  if (req2 && !aged2)
                     loss2_d = loss2_q + 2'd1;
               end
`endif
            end
         end
         SERVE: begin
            if (cnt_q == 8'd0 || done || !req_own) begin
               state_d = GAP;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         GAP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      grant1_d = (state_d == SERVE) && !owner_d;
      grant2_d = (state_d == SERVE) && owner_d;
      sari_d   = (state_d == GAP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         grant1_q <= 1'b0;
         grant2_q <= 1'b0;
         sari_q   <= 1'b0;
`ifdef ARB_AGING_EN
         loss1_q  <= 2'd0;
         loss2_q  <= 2'd0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         grant1_q <= grant1_d;
         grant2_q <= grant2_d;
         sari_q   <= sari_d;
`ifdef ARB_AGING_EN
         loss1_q  <= loss1_d;
         loss2_q  <= loss2_d;
`endif
      end
   end

   assign grant1  = grant1_q;
   assign grant2  = grant2_q;
   assign yesil   = grant1_q;
   assign kirmizi = grant2_q;
   assign sari    = sari_q;

endmodule
